// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, loader and memory-port signals shared by the data-memory arbiter.
// The slave modport is the arbiter's view; master is the requesters-plus-memory side.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [3:0]    c_dwe;
  logic          c_gnt;
  logic          c_stall;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;

  logic          l_req;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic [3:0]    l_dwe;
  logic          l_gnt;
  logic          l_rvalid;
  logic [DW-1:0] l_rdata;

  logic          m_en;
  logic [AW-3:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_dwe;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  c_req, c_addr, c_wdata, c_dwe,
    input  l_req, l_addr, l_wdata, l_dwe,
    input  m_rdata,
    output c_gnt, c_stall, c_rvalid, c_rdata,
    output l_gnt, l_rvalid, l_rdata,
    output m_en, m_addr, m_wdata, m_dwe
  );

  modport master (
    output c_req, c_addr, c_wdata, c_dwe,
    output l_req, l_addr, l_wdata, l_dwe,
    output m_rdata,
    input  c_gnt, c_stall, c_rvalid, c_rdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  m_en, m_addr, m_wdata, m_dwe
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / loader) arbiter for the single-port data memory with read-data routing.
// Define DMEM_ARB_RR_EN for round-robin; otherwise fixed CPU priority with a loader starvation guard.
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam logic OWN_C = 1'b0;
  localparam logic OWN_L = 1'b1;

  logic c_win;
  logic l_win;
  logic last_q, last_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;
  logic [3:0] sel_dwe;

`ifndef DMEM_ARB_RR_EN
  localparam int WCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(STARVE_LIMIT);
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
`endif

  always_comb begin
    c_win = 1'b0;
    l_win = 1'b0;
`ifdef DMEM_ARB_RR_EN
    if (bus.c_req && bus.l_req) begin
      if (last_q == OWN_C) l_win = 1'b1;
      else                 c_win = 1'b1;
    end else begin
      c_win = bus.c_req;
      l_win = bus.l_req;
    end
`else
    // A loader that has waited STARVE_LIMIT cycles overrides the CPU for one cycle
    if (bus.l_req && (wait_cnt_q == WAIT_MAX)) l_win = 1'b1;
    else if (bus.c_req)                        c_win = 1'b1;
    else                                       l_win = bus.l_req;
`endif
    if (!rst_n) begin
      c_win = 1'b0;
      l_win = 1'b0;
    end
  end

  always_comb begin
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    sel_dwe     = 4'b0000;
    if (c_win) begin
      bus.m_addr  = bus.c_addr[AW-1:2];
      bus.m_wdata = bus.c_wdata;
      sel_dwe     = bus.c_dwe;
    end else if (l_win) begin
      bus.m_addr  = bus.l_addr[AW-1:2];
      bus.m_wdata = bus.l_wdata;
      sel_dwe     = bus.l_dwe;
    end
  end

  assign bus.m_dwe    = sel_dwe;
  assign bus.m_en     = c_win | l_win;
  assign bus.c_gnt    = c_win;
  assign bus.l_gnt    = l_win;
  assign bus.c_stall  = rst_n & bus.c_req & ~c_win;

  // Read data is combinational from the memory; only the registered owner sees it
  assign bus.c_rvalid = rst_n & rd_pend_q & (rd_owner_q == OWN_C);
  assign bus.l_rvalid = rst_n & rd_pend_q & (rd_owner_q == OWN_L);
  assign bus.c_rdata  = bus.c_rvalid ? bus.m_rdata : '0;
  assign bus.l_rdata  = bus.l_rvalid ? bus.m_rdata : '0;

  always_comb begin
    rd_pend_d  = (c_win | l_win) && (sel_dwe == 4'b0000);
    rd_owner_d = l_win ? OWN_L : OWN_C;
    last_d     = last_q;
    if (c_win)      last_d = OWN_C;
    else if (l_win) last_d = OWN_L;
`ifndef DMEM_ARB_RR_EN
    wait_cnt_d = '0;
    if (bus.l_req && !l_win)
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q     <= OWN_L;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWN_C;
`ifndef DMEM_ARB_RR_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      last_q     <= last_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
`ifndef DMEM_ARB_RR_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a write-first synchronous memory model.
// Expected grant order follows DMEM_ARB_RR_EN when defined, fixed priority otherwise.
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [31:0] mem [0:63];
  logic exp_c [6];

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: byte writes, registered read of the word addressed this cycle
  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_dwe != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (bus.m_dwe[b]) mem[bus.m_addr[5:0]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
      end else begin
        bus.m_rdata <= mem[bus.m_addr[5:0]];
      end
    end
  end

  task automatic applyStimulus(input logic creq, input logic [31:0] caddr, input logic [3:0] cdwe,
                               input logic [31:0] cwdata, input logic lreq, input logic [31:0] laddr,
                               input logic [3:0] ldwe, input logic [31:0] lwdata);
    bus.c_req   = creq;
    bus.c_addr  = caddr;
    bus.c_dwe   = cdwe;
    bus.c_wdata = cwdata;
    bus.l_req   = lreq;
    bus.l_addr  = laddr;
    bus.l_dwe   = ldwe;
    bus.l_wdata = lwdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
    bus.m_rdata = '0;
    rst_n = 1'b0;
`ifdef DMEM_ARB_RR_EN
    exp_c = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);

    $display("[TB] reset state with both requests raised");
    @(negedge clk);
    applyStimulus(1'b1, 32'h10, 4'h0, 32'h0, 1'b1, 32'h20, 4'h0, 32'h0);
    #1;
    checkOutput("rst_c_gnt", 32'(bus.c_gnt), 32'd0);
    checkOutput("rst_l_gnt", 32'(bus.l_gnt), 32'd0);
    checkOutput("rst_m_en", 32'(bus.m_en), 32'd0);
    checkOutput("rst_m_addr", 32'(bus.m_addr), 32'd0);
    checkOutput("rst_c_rvalid", 32'(bus.c_rvalid), 32'd0);
    checkOutput("rst_l_rvalid", 32'(bus.l_rvalid), 32'd0);
    checkOutput("rst_c_rdata", bus.c_rdata, 32'd0);
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] lone CPU read");
    @(negedge clk);
    applyStimulus(1'b1, 32'h10, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    checkOutput("cpu_rd_gnt", 32'(bus.c_gnt), 32'd1);
    checkOutput("cpu_rd_lgnt", 32'(bus.l_gnt), 32'd0);
    checkOutput("cpu_rd_m_en", 32'(bus.m_en), 32'd1);
    checkOutput("cpu_rd_m_addr", 32'(bus.m_addr), 32'h4);
    checkOutput("cpu_rd_stall", 32'(bus.c_stall), 32'd0);
    checkOutput("cpu_rd_rvalid_early", 32'(bus.c_rvalid), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    checkOutput("cpu_rd_rvalid", 32'(bus.c_rvalid), 32'd1);
    checkOutput("cpu_rd_rdata", bus.c_rdata, 32'hA000_0004);
    checkOutput("cpu_rd_l_rvalid", 32'(bus.l_rvalid), 32'd0);
    checkOutput("cpu_rd_l_rdata", bus.l_rdata, 32'd0);

    $display("[TB] loader byte store then CPU load");
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h20, 4'b0001, 32'h0000_00AB);
    #1;
    checkOutput("ld_st_gnt", 32'(bus.l_gnt), 32'd1);
    checkOutput("ld_st_m_addr", 32'(bus.m_addr), 32'h8);
    checkOutput("ld_st_m_dwe", 32'(bus.m_dwe), 32'h1);
    checkOutput("ld_st_m_wdata", bus.m_wdata, 32'hAB);
    @(negedge clk);
    applyStimulus(1'b1, 32'h20, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    checkOutput("ld_st_no_rvalid", 32'(bus.l_rvalid), 32'd0);
    checkOutput("cpu_ld_gnt", 32'(bus.c_gnt), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    checkOutput("cpu_ld_rvalid", 32'(bus.c_rvalid), 32'd1);
    checkOutput("cpu_ld_rdata", bus.c_rdata, 32'hA000_00AB);
    checkOutput("cpu_ld_l_rvalid", 32'(bus.l_rvalid), 32'd0);

    $display("[TB] both requesters held from reset");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) applyStimulus(1'b1, 32'h30, 4'h0, 32'h0, 1'b1, 32'h40, 4'h0, 32'h0);
      #1;
      checkOutput($sformatf("tie_c_gnt_%0d", i), 32'(bus.c_gnt), 32'(exp_c[i]));
      checkOutput($sformatf("tie_l_gnt_%0d", i), 32'(bus.l_gnt), 32'(!exp_c[i]));
      checkOutput($sformatf("tie_stall_%0d", i), 32'(bus.c_stall), 32'(!exp_c[i]));
      if (i == 0) begin
        checkOutput("tie_c_rvalid_0", 32'(bus.c_rvalid), 32'd0);
        checkOutput("tie_l_rvalid_0", 32'(bus.l_rvalid), 32'd0);
      end else begin
        checkOutput($sformatf("tie_c_rvalid_%0d", i), 32'(bus.c_rvalid), 32'(exp_c[i-1]));
        checkOutput($sformatf("tie_l_rvalid_%0d", i), 32'(bus.l_rvalid), 32'(!exp_c[i-1]));
        checkOutput($sformatf("tie_c_rdata_%0d", i), bus.c_rdata, exp_c[i-1] ? 32'hA000_000C : 32'h0);
        checkOutput($sformatf("tie_l_rdata_%0d", i), bus.l_rdata, exp_c[i-1] ? 32'h0 : 32'hA000_0010);
      end
    end
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    checkOutput("tie_c_rvalid_last", 32'(bus.c_rvalid), 32'(exp_c[5]));
    checkOutput("tie_l_rvalid_last", 32'(bus.l_rvalid), 32'(!exp_c[5]));
    checkOutput("tie_l_rdata_last", bus.l_rdata, exp_c[5] ? 32'h0 : 32'hA000_0010);

    $display("[TB] reset right after a CPU read grant");
    @(negedge clk);
    applyStimulus(1'b1, 32'h10, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    checkOutput("mid_rst_gnt", 32'(bus.c_gnt), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    checkOutput("mid_rst_rvalid", 32'(bus.c_rvalid), 32'd0);
    checkOutput("mid_rst_rdata", bus.c_rdata, 32'd0);
    checkOutput("mid_rst_m_en", 32'(bus.m_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_rvalid", 32'(bus.c_rvalid), 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, 32'h10, 4'h0, 32'h0, 1'b1, 32'h20, 4'h0, 32'h0);
    #1;
    checkOutput("post_rst_tie_c", 32'(bus.c_gnt), 32'd1);
    checkOutput("post_rst_tie_l", 32'(bus.l_gnt), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    checkOutput("post_rst_rd_rvalid", 32'(bus.c_rvalid), 32'd1);
    checkOutput("post_rst_rd_rdata", bus.c_rdata, 32'hA000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-port data memory of the single-cycle CPU. Requester 0 is the CPU load/store path, driven by the decoded byte-write enables and load select. Requester 1 is the program loader/DMA port used to preload or inspect memory. The arbiter grants one requester per cycle, drives the memory port from the winner, and routes the 1-cycle-latency read data back to that requester. It also raises a stall to the CPU whenever the CPU's request is not granted.

## Interface
Parameters:
- AW, 32, address width (byte address; memory uses word index addr[AW-1:2])
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive denied loader cycles before a forced loader grant (fixed-priority mode only)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- c_req  in  1  CPU request, held until granted
- c_addr  in  AW  CPU byte address
- c_wdata  in  DW  CPU store data
- c_dwe  in  4  CPU byte-write enables; 4'b0000 means read
- c_gnt  out  1  CPU granted this cycle
- c_stall  out  1  c_req & ~c_gnt
- c_rvalid  out  1  CPU read data valid
- c_rdata  out  DW  CPU read data
- l_req, l_addr, l_wdata, l_dwe, l_gnt, l_rvalid, l_rdata: loader equivalents, same widths and meanings
- m_en  out  1  memory access enable
- m_addr  out  AW-2  word address
- m_wdata  out  DW  write data
- m_dwe  out  4  byte-write enables
- m_rdata  in  DW  synchronous read data, valid the cycle after m_en with m_dwe==0

## Operation
- Grant is combinational from the requests and the registered priority state. At most one of c_gnt and l_gnt is high. A grant is given only to an asserting requester.
- While rst_n=0: c_gnt, l_gnt and m_en are forced to 0.
- Memory port mux:
  - m_en = c_gnt | l_gnt.
  - m_addr, m_wdata, m_dwe come from the winner.
  - When no requester is granted, m_dwe = 0 and m_addr = 0.
- Read tracking: a granted access with dwe==0 sets rd_pend=1 and rd_owner=winner. Otherwise rd_pend=0.
- The cycle after such a grant:
  - the owner's rvalid is 1;
  - the owner's rdata = m_rdata;
  - the non-owner's rdata is 0.
- Writes produce no rvalid.
- Priority state:
  - last: 1 bit, holds the last winner; reset value = loader.
  - wait_cnt: $clog2(STARVE_LIMIT+1) bits; reset value = 0.
- Fixed-priority arbitration:
  - The CPU wins any tie.
  - wait_cnt increments (saturating at STARVE_LIMIT) each cycle l_req=1 and l_gnt=0.
  - wait_cnt clears when l_gnt=1 or l_req=0.
  - When wait_cnt==STARVE_LIMIT and l_req=1, the loader wins even if c_req=1 (forced grant). The CPU stalls that cycle.
- Simultaneous requests or the forced grant change ownership only for that cycle. There is no burst locking.

## Timing
- Grant latency: 0 cycles. A lone request is granted in the same cycle it is asserted.
- Read latency: 1 cycle from grant to rvalid. Back-to-back reads by alternating owners each return correctly, because rd_owner is registered per grant.
- Reset values: c_rvalid = l_rvalid = 0; c_rdata = l_rdata = 0; rd_pend = 0; last = loader; wait_cnt = 0.
- Reset mid-operation: a pending read is dropped and no rvalid follows. The first post-reset tie goes to the CPU.
- Write and read to the same address in consecutive cycles: the read returns the new data, per the memory's write-first behaviour. The arbiter adds no bypass.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - On a tie, the requester not equal to `last` wins.
  - `last` updates on every grant.
  - wait_cnt and STARVE_LIMIT logic are not built; STARVE_LIMIT is ignored.
- DMEM_ARB_RR_EN undefined: fixed CPU priority with the starvation guard described above. `last` is still updated but does not affect the decision.

## Test plan
- Reset, then a lone CPU read: c_req=1, c_addr=0x10, c_dwe=0. Required: c_gnt=1 and m_addr=0x4 in the same cycle; next cycle c_rvalid=1 and c_rdata = preloaded word.
- Loader store then CPU load: l_dwe=4'b0001, l_wdata=0xAB at 0x20, then CPU read 0x20. Required: byte 0 reads back 0xAB, and l_rvalid stays 0 for the store.
- Fixed priority, both requesters held, STARVE_LIMIT=4. Required: CPU granted 4 cycles, loader forced in cycle 5 with c_stall=1, then CPU again; l_rvalid is asserted after the forced read.
- DMEM_ARB_RR_EN, both requesters held for 6 cycles from reset. Required: grants go C, L, C, L, C, L, and each rvalid is routed to the correct owner.
- Reset asserted the cycle after a CPU read grant. Required: c_rvalid=0 that cycle and after, and all outputs are 0 while rst_n=0.
